mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multi-cycle MIPS-lite core: one FSM-sequenced datapath sharing one ALU and one memory port over
//  FETCH/DECODE/EXEC/MEM/WB states. Talks to an external unified instruction/data memory through a
//  req/ready handshake with arbitrary wait states.
//  Instruction set: addu, subu, slt, ori, addiu, lui, lw, sw, beq, j, jal, jr, syscall (halt).
//  Successor to the single-cycle core: stalls on slow memory; halts cleanly on illegal instructions.
// PARAMETERS
//  RESET_PC        32'h0000_3000  PC loaded on reset; first fetch address
//  ADDR_W          32             mem_addr width; the PC is kept at 32 bits, mem_addr = pc[ADDR_W-1:0]
//  HALT_ON_ILLEGAL 1              1: an unknown opcode/funct halts with err=1; 0: it retires as a NOP
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  mem_req    out  1       memory request valid
//  mem_we     out  1       1 = write (sw), 0 = read (fetch/lw)
//  mem_addr   out  ADDR_W  byte address, word aligned
//  mem_wdata  out  32      store data (rt)
//  mem_rdata  in   32      read data; valid in the cycle mem_ready=1
//  mem_ready  in   1       transfer completes in any cycle with mem_req & mem_ready
//  retire     out  1       1-cycle pulse as each instruction completes
//  pc_o       out  32      PC of the current instruction (debug)
//  halt       out  1       core stopped (syscall or error); sticky until reset
//  err        out  1       halt cause is illegal instr or misaligned lw/sw
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC; all 32 GPRs=0; state=FETCH; mem_req=0.
//   retire=0, halt=0, err=0. The first mem_req rises in the first clock after rst_n deasserts.
//  Handshake: once mem_req=1, mem_addr/mem_we/mem_wdata are held stable until mem_req&mem_ready.
//   mem_req drops the cycle after completion. The core never withdraws a request.
//   mem_ready while mem_req=0 is ignored.
//  FETCH : mem_req=1, we=0, addr=pc. On ready: latch IR<=mem_rdata, pc_next<=pc+4, go DECODE.
//  DECODE: read rs/rt into A/B; precompute branch target = pc+4+(sext(imm16)<<2). Then:
//   syscall -> HALT; illegal -> HALT (err=1) or retire as NOP per HALT_ON_ILLEGAL; otherwise EXEC.
//  EXEC  : ALU op. Zero-extend imm for ori, sign-extend for addiu/lw/sw; lui gives {imm16,16'h0}.
//   slt is signed compare; addu/subu/addiu wrap mod 2^32 and never trap.
//   beq: pc<=target if A==B else pc+4. j: pc<={pc_plus4[31:28],idx26,2'b00}.
//   jal: j target, and $31<=pc+4. jr: pc<=A.
//   beq/j/jal/jr retire here -> FETCH.
//   lw/sw with addr[1:0]!=0 -> HALT, err=1, no bus access.
//   lw/sw -> MEM; ALU ops -> WB.
//  MEM   : lw: req we=0, on ready -> WB. sw: req we=1, wdata=B, on ready -> retire -> FETCH.
//  WB    : write rd (R-type) / rt (I-type) / loaded data. Writes to $0 are discarded. Retire -> FETCH.
//  HALT  : absorbing; mem_req=0; halt=1. Only rst_n leaves it.
//  Latency with zero wait states: beq/j/jal/jr 3 cycles; R/I ALU and sw 4; lw 5.
//   Each wait cycle adds 1.
//  pc wraps mod 2^32. pc_o updates at retire.
//  rst_n asserted mid-transaction: mem_req drops immediately (async); the access is abandoned.
// STRUCTURE
//  Shared package mips_pkg:
//   - opcode/funct localparams (OP_RTYPE, OP_ORI, F_ADDU, F_SYSCALL, ...);
//   - alu_op_t enum;
//   - state_t enum {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT}.
//  One sub-module: mips_mc_regfile (2 async read, 1 sync write, $0 hardwired, async active-low clear).
//  FSM, decode, ALU and next-PC logic live in this module.
// TESTING
//  1 Reset: rst_n=0 -> mem_req=0, halt=0; first request after release has addr=32'h3000.
//  2 ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2; sw $3,0($0); zero wait states
//    -> write of 32'hABCD1234 to addr 0; retire pulses at cycles 4, 8, 12, 16.
//  3 Random mem_ready stalls of 0-7 cycles on a lw/sw program -> addr/we/wdata stable while waiting;
//    register results identical to the zero-wait run.
//  4 beq $0,$0,-1 with taken/not-taken variants; j/jal/jr to 0x3010; syscall
//    -> correct PC sequence; $31=0x3004 after jal at 0x3000; halt=1, err=0 after syscall.
//  5 lw from addr 0x2 -> halt=1, err=1, no mem_req for the data phase.
//    Opcode 6'h3F -> halt+err (HALT_ON_ILLEGAL=1) or NOP retire (0).
//  6 addu $0,$1,$1 -> $0 reads 0. rst_n pulsed during a stalled fetch -> restart cleanly at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-lite core: opcodes, functs,
// ALU operations, FSM states and a legality decoder.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_JR      = 6'h08;
   localparam logic [5:0] F_SYSCALL = 6'h0C;
   localparam logic [5:0] F_ADDU    = 6'h21;
   localparam logic [5:0] F_SUBU    = 6'h23;
   localparam logic [5:0] F_SLT     = 6'h2A;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_OR, ALU_LUI} alu_op_t;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   // True for every opcode/funct pair the core implements (syscall included).
   function automatic logic is_legal(input logic [31:0] ir);
      logic ok;
      ok = 1'b0;
      case (ir[31:26])
         OP_RTYPE: ok = (ir[5:0] == F_ADDU) || (ir[5:0] == F_SUBU) || (ir[5:0] == F_SLT) ||
                        (ir[5:0] == F_JR)   || (ir[5:0] == F_SYSCALL);
         OP_J, OP_JAL, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous reads, one synchronous write.
// Entry 0 is cleared by reset and never written, so $0 always reads zero.
module mips_mc_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] regs_q [0:31];

   // Register storage: cleared on reset, writes to $0 dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-lite core. One FSM sequences FETCH/DECODE/EXEC/MEM/WB over
// a shared ALU and a single req/ready memory port that tolerates wait states.
module mips_multicycle_core
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_3000,
   parameter int          ADDR_W          = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic [31:0]       pc_o,
   output logic              halt,
   output logic              err
);

   state_t      state_q, state_d;
   logic        started_q, started_d;   // holds off the first request until reset has released
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] alu_q, alu_d;           // ALU result, doubles as the lw/sw address
   logic [31:0] mdr_q, mdr_d;
   logic        err_q, err_d;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
   logic [4:0]  rf_waddr;
   logic        rf_we;
   alu_op_t     alu_op;
   logic [31:0] alu_b, alu_res;
   logic        xfer;

   assign op    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign imm   = ir_q[15:0];
   assign funct = ir_q[5:0];

   mips_mc_regfile u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr1_i (rs),
      .raddr2_i (rt),
      .rdata1_o (rf_rdata1),
      .rdata2_o (rf_rdata2),
      .we_i     (rf_we),
      .waddr_i  (rf_waddr),
      .wdata_i  (rf_wdata)
   );

   // The bus is driven straight from registered state, so address/data stay
   // put for the whole wait; reset clears started_q and drops mem_req at once.
   assign mem_req   = started_q && ((state_q == S_FETCH) || (state_q == S_MEM));
   assign mem_we    = (state_q == S_MEM) && (op == OP_SW);
   assign mem_addr  = (state_q == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
   assign mem_wdata = b_q;
   assign xfer      = mem_req && mem_ready;
   assign pc_o      = pc_q;
   assign halt      = (state_q == S_HALT);
   assign err       = err_q;

   // ALU operand select and operation.
   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = {{16{imm[15]}}, imm};
      case (op)
         OP_RTYPE: begin
            alu_b = b_q;
            case (funct)
               F_SUBU:  alu_op = ALU_SUB;
               F_SLT:   alu_op = ALU_SLT;
               default: alu_op = ALU_ADD;
            endcase
         end
         OP_ORI: begin
            alu_op = ALU_OR;
            alu_b  = {16'h0000, imm};
         end
         OP_LUI:  alu_op = ALU_LUI;
         default: alu_op = ALU_ADD;
      endcase
      alu_res = a_q + alu_b;
      case (alu_op)
         ALU_SUB: alu_res = a_q - alu_b;
         ALU_SLT: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
         ALU_OR:  alu_res = a_q | alu_b;
         ALU_LUI: alu_res = {imm, 16'h0000};
         default: alu_res = a_q + alu_b;
      endcase
   end

   // Next-state, datapath register updates, register write and retire pulse.
   always_comb begin
      state_d   = state_q;
      started_d = 1'b1;
      pc_d      = pc_q;
      pc4_d     = pc4_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      tgt_d     = tgt_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      err_d     = err_q;
      rf_we     = 1'b0;
      rf_waddr  = 5'd0;
      rf_wdata  = 32'd0;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (xfer) begin
               ir_d    = mem_rdata;
               pc4_d   = pc_q + 32'd4;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d   = rf_rdata1;
            b_d   = rf_rdata2;
            tgt_d = pc4_q + {{14{imm[15]}}, imm, 2'b00};
            if (!is_legal(ir_q)) begin
               if (HALT_ON_ILLEGAL) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  retire  = 1'b1;
                  pc_d    = pc4_q;
                  state_d = S_FETCH;
               end
            end else if ((op == OP_RTYPE) && (funct == F_SYSCALL)) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_d = alu_res;
            case (op)
               OP_BEQ: begin
                  pc_d    = (a_q == b_q) ? tgt_q : pc4_q;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_J, OP_JAL: begin
                  pc_d    = {pc4_q[31:28], ir_q[25:0], 2'b00};
                  retire  = 1'b1;
                  state_d = S_FETCH;
                  if (op == OP_JAL) begin
                     rf_we    = 1'b1;
                     rf_waddr = 5'd31;
                     rf_wdata = pc4_q;
                  end
               end
               OP_LW, OP_SW: begin
                  if (alu_res[1:0] != 2'b00) begin
                     err_d   = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     state_d = S_MEM;
                  end
               end
               default: begin
                  if ((op == OP_RTYPE) && (funct == F_JR)) begin
                     pc_d    = a_q;
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            endcase
         end
         S_MEM: begin
            if (xfer) begin
               if (op == OP_LW) begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  pc_d    = pc4_q;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            rf_waddr = (op == OP_RTYPE) ? rd : rt;
            rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
            retire   = 1'b1;
            pc_d     = pc4_q;
            state_d  = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         started_q <= 1'b0;
         pc_q      <= RESET_PC;
         pc4_q     <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         tgt_q     <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= started_d;
         pc_q      <= pc_d;
         pc4_q     <= pc4_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         tgt_q     <= tgt_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a word memory with a randomisable
// wait-state responder, plus a second core built to retire illegal opcodes.
module tb_mips_multicycle_core;

   localparam logic [31:0] SYSC = 32'h0000_000C;
   localparam logic [31:0] ILL  = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, retire, halt, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
   logic        mem_ready = 1'b0;

   logic        req2, we2, ret2, halt2, err2;
   logic [31:0] addr2, wd2, rd2, pc2;
   logic        rdy2 = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:4095];
   int          stall_max = 0;
   bit          hold_ready = 1'b0;
   bit          pending = 1'b0;
   int          wcnt = 0;
   int          viol = 0;
   int          n_xfer = 0;
   int          n_wr = 0;
   logic [31:0] lat_addr, lat_wdata;
   logic        lat_we;

   int          ret_at[$];
   logic [31:0] ret_pc[$];

   always #5 clk = ~clk;

   mips_multicycle_core dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
      .pc_o(pc_o), .halt(halt), .err(err)
   );

   mips_multicycle_core #(.HALT_ON_ILLEGAL(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
      .mem_wdata(wd2), .mem_rdata(rd2), .mem_ready(rdy2), .retire(ret2),
      .pc_o(pc2), .halt(halt2), .err(err2)
   );

   assign mem_rdata = mem[mem_addr[13:2]];
   // Second core sees an illegal word at the reset PC and syscall everywhere else.
   assign rd2 = (addr2 == 32'h0000_3000) ? ILL : SYSC;

   // Responder: picks a wait count per request and watches that the request is held.
   always @(negedge clk) begin
      if (mem_req) begin
         if (!pending) begin
            pending   = 1'b1;
            lat_addr  = mem_addr;
            lat_we    = mem_we;
            lat_wdata = mem_wdata;
            wcnt      = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
         end else if (mem_addr !== lat_addr || mem_we !== lat_we ||
                      (mem_we && mem_wdata !== lat_wdata)) begin
            viol++;
         end
         mem_ready = hold_ready ? 1'b0 : (wcnt == 0);
         if (!hold_ready && wcnt > 0) wcnt--;
      end else begin
         pending   = 1'b0;
         mem_ready = 1'b0;
      end
   end

   // Completed transfers: count them and commit stores.
   always @(posedge clk) begin
      if (mem_req && mem_ready) begin
         n_xfer++;
         if (mem_we) begin
            n_wr++;
            mem[mem_addr[13:2]] = mem_wdata;
         end
         pending = 1'b0;
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] f);
      return {6'h00, rs, rt, rd, 5'h00, f};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
      return {op, tgt[27:2]};
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem[a[13:2]];
   endfunction

   task automatic load(input logic [31:0] a, input logic [31:0] w);
      mem[a[13:2]] = w;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      hold_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_xfer = 0;
      n_wr   = 0;
      viol   = 0;
      rst_n  = 1'b1;
   endtask

   // Steps until halt or the budget runs out; cycle 1 is the first cycle with mem_req.
   task automatic run_prog(input int max_cyc);
      bit seen;
      int n;
      seen = 1'b0;
      n    = 0;
      ret_at.delete();
      ret_pc.delete();
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         #1;
         if (!seen && mem_req) seen = 1'b1;
         if (seen) n++;
         if (retire) begin
            ret_at.push_back(n);
            ret_pc.push_back(pc_o);
         end
         if (halt) break;
      end
   endtask

   task automatic test_reset();
      clear_mem();
      load(32'h3000, SYSC);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
      n_checks++; if (halt !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_halt_err: got %b%b want 00", halt, err); end
      n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b want 0", retire); end
      n_checks++; if (pc_o !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want 00003000", pc_o); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL release_req_early: got %b want 0", mem_req); end
      @(negedge clk);
      #1;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", mem_req); end
      n_checks++; if (mem_addr !== 32'h3000 || mem_we !== 1'b0) begin n_fail++; $display("FAIL first_req_addr: got %h we=%b want 00003000 we=0", mem_addr, mem_we); end
      run_prog(50);
      n_checks++; if (halt !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL reset_syscall: got halt=%b err=%b want 1 0", halt, err); end
   endtask

   task automatic test_alu_store();
      int exp_at[4];
      exp_at = '{4, 8, 12, 16};
      clear_mem();
      load(32'h0000, 32'hFFFF_FFFF);
      load(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
      load(32'h3004, enc_i(6'h0F, 5'd0, 5'd2, 16'hABCD));
      load(32'h3008, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
      load(32'h300C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0000));
      load(32'h3010, SYSC);
      stall_max = 0;
      do_reset();
      run_prog(200);
      n_checks++; if (ret_at.size() != 4) begin n_fail++; $display("FAIL alu_retire_count: got %0d want 4", ret_at.size()); end
      for (int i = 0; i < 4 && i < ret_at.size(); i++) begin
         n_checks++; if (ret_at[i] != exp_at[i]) begin n_fail++; $display("FAIL alu_retire_cycle[%0d]: got %0d want %0d", i, ret_at[i], exp_at[i]); end
      end
      n_checks++; if (n_wr != 1) begin n_fail++; $display("FAIL alu_write_count: got %0d want 1", n_wr); end
      n_checks++; if (rd_mem(32'h0) !== 32'hABCD_1234) begin n_fail++; $display("FAIL alu_store_data: got %h want abcd1234", rd_mem(32'h0)); end
      n_checks++; if (halt !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL alu_halt: got halt=%b err=%b want 1 0", halt, err); end
   endtask

   task automatic test_stall();
      for (int p = 0; p < 2; p++) begin
         clear_mem();
         load(32'h0100, 32'hDEAD_BEEF);
         load(32'h3000, enc_i(6'h09, 5'd0, 5'd1, 16'h0100));
         load(32'h3004, enc_i(6'h23, 5'd1, 5'd2, 16'h0000));
         load(32'h3008, enc_i(6'h09, 5'd2, 5'd3, 16'hFFFF));
         load(32'h300C, enc_r(5'd3, 5'd0, 5'd4, 6'h2A));
         load(32'h3010, enc_r(5'd0, 5'd2, 5'd5, 6'h23));
         load(32'h3014, enc_i(6'h2B, 5'd1, 5'd3, 16'h0004));
         load(32'h3018, enc_i(6'h2B, 5'd1, 5'd4, 16'h0008));
         load(32'h301C, enc_i(6'h2B, 5'd1, 5'd5, 16'h000C));
         load(32'h3020, SYSC);
         stall_max = (p == 0) ? 0 : 7;
         do_reset();
         run_prog(2000);
         n_checks++; if (ret_at.size() != 8) begin n_fail++; $display("FAIL stall%0d_retires: got %0d want 8", p, ret_at.size()); end
         n_checks++; if (rd_mem(32'h104) !== 32'hDEAD_BEEE) begin n_fail++; $display("FAIL stall%0d_addiu: got %h want deadbeee", p, rd_mem(32'h104)); end
         n_checks++; if (rd_mem(32'h108) !== 32'h0000_0001) begin n_fail++; $display("FAIL stall%0d_slt: got %h want 00000001", p, rd_mem(32'h108)); end
         n_checks++; if (rd_mem(32'h10C) !== 32'h2152_4111) begin n_fail++; $display("FAIL stall%0d_subu: got %h want 21524111", p, rd_mem(32'h10C)); end
         n_checks++; if (viol != 0) begin n_fail++; $display("FAIL stall%0d_hold: got %0d unstable cycles want 0", p, viol); end
         n_checks++; if (halt !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL stall%0d_halt: got halt=%b err=%b want 1 0", p, halt, err); end
      end
      stall_max = 0;
   endtask

   task automatic test_branch_jump();
      logic [31:0] exp_pc[6];
      exp_pc = '{32'h3000, 32'h3010, 32'h3014, 32'h3004, 32'h3008, 32'h3018};
      clear_mem();
      load(32'h3000, enc_j(6'h03, 32'h3010));
      load(32'h3004, enc_i(6'h2B, 5'd0, 5'd31, 16'h0020));
      load(32'h3008, enc_j(6'h02, 32'h3018));
      load(32'h300C, ILL);
      load(32'h3010, enc_i(6'h0D, 5'd0, 5'd1, 16'h0005));
      load(32'h3014, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
      load(32'h3018, enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF));
      load(32'h301C, SYSC);
      do_reset();
      run_prog(300);
      n_checks++; if (ret_pc.size() != 6) begin n_fail++; $display("FAIL br_retire_count: got %0d want 6", ret_pc.size()); end
      for (int i = 0; i < 6 && i < ret_pc.size(); i++) begin
         n_checks++; if (ret_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL br_pc_seq[%0d]: got %h want %h", i, ret_pc[i], exp_pc[i]); end
      end
      if (ret_at.size() > 0) begin
         n_checks++; if (ret_at[0] != 3) begin n_fail++; $display("FAIL br_jal_latency: got %0d want 3", ret_at[0]); end
      end
      n_checks++; if (rd_mem(32'h20) !== 32'h3004) begin n_fail++; $display("FAIL br_jal_link: got %h want 00003004", rd_mem(32'h20)); end
      n_checks++; if (halt !== 1'b1 || err !== 1'b0 || pc_o !== 32'h301C) begin n_fail++; $display("FAIL br_halt: got halt=%b err=%b pc=%h want 1 0 0000301c", halt, err, pc_o); end
   endtask

   task automatic test_beq_taken();
      clear_mem();
      load(32'h3000, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
      do_reset();
      run_prog(13);
      n_checks++; if (ret_pc.size() != 4) begin n_fail++; $display("FAIL beq_loop_count: got %0d want 4", ret_pc.size()); end
      for (int i = 0; i < ret_pc.size(); i++) begin
         n_checks++; if (ret_pc[i] !== 32'h3000 || ret_at[i] != 3 * (i + 1)) begin n_fail++; $display("FAIL beq_loop[%0d]: got pc=%h cyc=%0d want 00003000 %0d", i, ret_pc[i], ret_at[i], 3 * (i + 1)); end
      end
      n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL beq_loop_halt: got %b want 0", halt); end
      clear_mem();
      load(32'h3000, enc_i(6'h04, 5'd0, 5'd0, 16'h0001));
      load(32'h3004, ILL);
      load(32'h3008, SYSC);
      do_reset();
      run_prog(100);
      n_checks++; if (halt !== 1'b1 || err !== 1'b0 || pc_o !== 32'h3008) begin n_fail++; $display("FAIL beq_fwd: got halt=%b err=%b pc=%h want 1 0 00003008", halt, err, pc_o); end
   endtask

   task automatic test_errors();
      clear_mem();
      load(32'h3000, enc_i(6'h23, 5'd0, 5'd2, 16'h0002));
      do_reset();
      run_prog(100);
      n_checks++; if (halt !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL misalign_halt: got halt=%b err=%b want 1 1", halt, err); end
      n_checks++; if (n_xfer != 1) begin n_fail++; $display("FAIL misalign_no_data_phase: got %0d transfers want 1", n_xfer); end
      n_checks++; if (ret_at.size() != 0) begin n_fail++; $display("FAIL misalign_retire: got %0d want 0", ret_at.size()); end
      clear_mem();
      load(32'h3000, ILL);
      do_reset();
      run_prog(100);
      n_checks++; if (halt !== 1'b1 || err !== 1'b1 || pc_o !== 32'h3000) begin n_fail++; $display("FAIL illegal_halt: got halt=%b err=%b pc=%h want 1 1 00003000", halt, err, pc_o); end
   endtask

   task automatic test_illegal_nop();
      int nret;
      logic [31:0] rpc;
      nret = 0;
      rpc  = 32'h0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (ret2) begin nret++; rpc = pc2; end
      end
      n_checks++; if (nret != 1 || rpc !== 32'h3000) begin n_fail++; $display("FAIL nop_retire: got %0d retires pc=%h want 1 00003000", nret, rpc); end
      n_checks++; if (halt2 !== 1'b1 || err2 !== 1'b0 || pc2 !== 32'h3004) begin n_fail++; $display("FAIL nop_halt: got halt=%b err=%b pc=%h want 1 0 00003004", halt2, err2, pc2); end
   endtask

   task automatic test_zero_reg();
      clear_mem();
      load(32'h0030, 32'hFFFF_FFFF);
      load(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h0005));
      load(32'h3004, enc_r(5'd1, 5'd1, 5'd0, 6'h21));
      load(32'h3008, enc_i(6'h2B, 5'd0, 5'd0, 16'h0030));
      load(32'h300C, enc_r(5'd0, 5'd1, 5'd4, 6'h21));
      load(32'h3010, enc_i(6'h2B, 5'd0, 5'd4, 16'h0034));
      load(32'h3014, SYSC);
      do_reset();
      run_prog(200);
      n_checks++; if (rd_mem(32'h30) !== 32'h0) begin n_fail++; $display("FAIL zero_reg: got %h want 00000000", rd_mem(32'h30)); end
      n_checks++; if (rd_mem(32'h34) !== 32'h5) begin n_fail++; $display("FAIL zero_reg_src: got %h want 00000005", rd_mem(32'h34)); end
   endtask

   task automatic test_reset_mid_fetch();
      clear_mem();
      load(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h0077));
      load(32'h3004, enc_i(6'h2B, 5'd0, 5'd1, 16'h0040));
      load(32'h3008, SYSC);
      do_reset();
      hold_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL midrst_stalled: got req=%b addr=%h want 1 00003000", mem_req, mem_addr); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: got %b want 0", mem_req); end
      repeat (2) @(negedge clk);
      hold_ready = 1'b0;
      n_xfer = 0;
      rst_n  = 1'b1;
      run_prog(200);
      n_checks++; if (ret_at.size() < 1 || ret_at[0] != 4) begin n_fail++; $display("FAIL midrst_restart: got %0d retires want first at cycle 4", ret_at.size()); end
      n_checks++; if (rd_mem(32'h40) !== 32'h77 || halt !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_result: got %h halt=%b err=%b want 00000077 1 0", rd_mem(32'h40), halt, err); end
   endtask

   initial begin
      test_reset();
      test_alu_store();
      test_stall();
      test_branch_jump();
      test_beq_taken();
      test_errors();
      test_illegal_nop();
      test_zero_reg();
      test_reset_mid_fetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
